// File: rtl/alu_defs.sv
// Shared definitions for the execute-stage ALU: opcode and FSM state enums, default width.
package alu_defs;

    localparam int ALU_XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_BEQ  = 4'd8,
        ALU_BNE  = 4'd9,
        ALU_BLT  = 4'd10,
        ALU_BGE  = 4'd11,
        ALU_NOP  = 4'd12,
        ALU_BLTU = 4'd13,
        ALU_BGEU = 4'd14,
        ALU_MUL  = 4'd15
    } alu_op_t;

    typedef enum logic {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_STEP multiplier bits per cycle (low XLEN bits only).
// done is high during the final iteration, when product_lo already holds the finished product.
module alu_mul_iter #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] product_lo
);
    localparam int ITERS = XLEN / MUL_STEP;
    localparam int CW    = $clog2(ITERS + 1);

    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] partial;
    logic [CW-1:0]   count;

    // Accumulator plus this cycle's MUL_STEP partial products.
    always_comb begin
        partial = acc;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (mplier[j]) begin
                partial = partial + (mcand << j);
            end
        end
    end

    assign done       = (count == CW'(1));
    assign product_lo = partial;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= CW'(ITERS);
        end else if (count != '0) begin
            acc    <= partial;
            mcand  <= mcand << MUL_STEP;
            mplier <= mplier >> MUL_STEP;
            count  <= count - CW'(1);
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes on both sides and a registered output.
// Define ALU_MUL_EN to add the iterative multiplier (MUL_RUN state + alu_mul_iter).
module alu_exec_unit
    import alu_defs::*;
#(
    parameter int XLEN     = ALU_XLEN,
    parameter int TAG_W    = 5,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int SHW = $clog2(XLEN);

    alu_op_t          op;
    alu_state_t       state;
    alu_state_t       state_next;
    logic             accept;
    logic             single_load;
    logic             mul_start;
    logic             mul_done;
    logic [SHW-1:0]   shamt;
    logic [XLEN-1:0]  alu_res;
    logic [XLEN-1:0]  mul_product;
    logic [TAG_W-1:0] mul_tag;

    if (XLEN < 8 || (XLEN % MUL_STEP) != 0) begin : g_param_check
        $error("alu_exec_unit: XLEN must be >= 8 and divisible by MUL_STEP");
    end

    assign op       = alu_op_t'(in_op);
    assign shamt    = in_b[SHW-1:0];
    assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

`ifdef ALU_MUL_EN
    logic mul_last;

    assign mul_start   = accept && (op == ALU_MUL);
    assign single_load = accept && (op != ALU_MUL);
    assign mul_done    = (state == MUL_RUN) && mul_last;
    assign busy        = (state == MUL_RUN);

    alu_mul_iter #(
        .XLEN     (XLEN),
        .MUL_STEP (MUL_STEP)
    ) u_mul (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (flush),
        .start      (mul_start),
        .a          (in_a),
        .b          (in_b),
        .done       (mul_last),
        .product_lo (mul_product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_tag <= '0;
        end else if (mul_start) begin
            mul_tag <= in_tag;
        end
    end
`else
    // Without the multiplier MUL falls through the single-cycle path and yields 0.
    assign mul_start   = 1'b0;
    assign single_load = accept;
    assign mul_done    = 1'b0;
    assign busy        = 1'b0;
    assign mul_product = '0;
    assign mul_tag     = '0;
`endif

    always_comb begin
        alu_res = '0;
        case (op)
            ALU_ADD:  alu_res = in_a + in_b;
            ALU_SUB:  alu_res = in_a - in_b;
            ALU_AND:  alu_res = in_a & in_b;
            ALU_OR:   alu_res = in_a | in_b;
            ALU_XOR:  alu_res = in_a ^ in_b;
            ALU_SLL:  alu_res = in_a << shamt;
            ALU_SRL:  alu_res = in_a >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(in_a) >>> shamt);
            ALU_BEQ:  alu_res = XLEN'(in_a == in_b);
            ALU_BNE:  alu_res = XLEN'(in_a != in_b);
            ALU_BLT:  alu_res = XLEN'($signed(in_a) < $signed(in_b));
            ALU_BGE:  alu_res = XLEN'($signed(in_a) >= $signed(in_b));
            ALU_BLTU: alu_res = XLEN'(in_a < in_b);
            ALU_BGEU: alu_res = XLEN'(in_a >= in_b);
            default:  alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Flush outranks both a new MUL and a completing one.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (mul_start) state_next = MUL_RUN;
                MUL_RUN: if (mul_done)  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // A load in the same edge as a consume keeps out_valid high for back-to-back issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (single_load) begin
            out_valid  <= 1'b1;
            out_result <= alu_res;
            out_tag    <= in_tag;
        end else if (mul_done) begin
            out_valid  <= 1'b1;
            out_result <= mul_product;
            out_tag    <= mul_tag;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
